// File: rtl/median3x3_stream_ctrl_if.sv
// median3x3_stream_ctrl_if: raster pixel input stream and median output stream handshakes
interface median3x3_stream_ctrl_if #(parameter int PIX_W = 8);
    logic [PIX_W-1:0] in_data;
    logic             in_valid;
    logic             in_sof;
    logic             in_ready;
    logic [PIX_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_eof;
    modport master (output in_data, in_valid, in_sof, out_ready, input in_ready, out_data, out_valid, out_eof);
    modport slave (input in_data, in_valid, in_sof, out_ready, output in_ready, out_data, out_valid, out_eof);
endinterface

// File: rtl/median3x3_stream_ctrl.sv
// median3x3_stream_ctrl: 3x3 median over a raster pixel stream; MEDIAN_STATS_EN adds frame_cnt/abort_cnt
module median_filter (
    input  logic [71:0] win,
    output logic [7:0]  med
);
    logic [3:0] lt;
    logic [3:0] le;
    // rank select: the median has at most 4 smaller and at least 5 not-larger neighbours
    always_comb begin
        med = '0;
        lt = '0;
        le = '0;
        for (int i = 0; i < 9; i++) begin
            lt = '0;
            le = '0;
            for (int j = 0; j < 9; j++) begin
                lt = lt + {3'b0, win[8*j +: 8] < win[8*i +: 8]};
                le = le + {3'b0, win[8*j +: 8] <= win[8*i +: 8]};
            end
            med = (lt <= 4'd4 && le >= 4'd5) ? win[8*i +: 8] : med;
        end
    end
endmodule

module median3x3_stream_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    median3x3_stream_ctrl_if.slave s,
    output logic frame_done
`ifdef MEDIAN_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [7:0]  abort_cnt
`endif
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    col;
    logic [CW-1:0]    idx;
    logic [RW-1:0]    row;
    logic [PIX_W-1:0] lb0 [IMG_W];
    logic [PIX_W-1:0] lb1 [IMG_W];
    // only the two retained columns are stored; the third is the column arriving this cycle
    logic [PIX_W-1:0] w1 [3];
    logic [PIX_W-1:0] w2 [3];
    logic [PIX_W-1:0] top;
    logic [PIX_W-1:0] mid;
    logic [PIX_W-1:0] med;
    logic             rdy;
    logic             take;
    logic             prod;
    logic             last;

    assign rdy = rst_n && state != DONE && (!s.out_valid || s.out_ready);
    assign s.in_ready = rdy;
    assign take = s.in_valid && rdy && (state == RUN || s.in_sof);
    assign idx = s.in_sof ? '0 : col;
    assign top = lb1[idx];
    assign mid = lb0[idx];
    assign last = row == RW'(IMG_H - 1) && col == CW'(IMG_W - 1);
    assign prod = take && !s.in_sof && row >= RW'(2) && col >= CW'(2);

    median_filter u_med (
        .win({w1[0], w1[1], w1[2], w2[0], w2[1], w2[2], top, mid, s.in_data}),
        .med(med)
    );

    // line buffers: read-before-write pushes the column down one row
    always_ff @(posedge clk) begin
        if (take) begin
            lb1[idx] <= mid;
            lb0[idx] <= s.in_data;
        end
    end

    // control FSM, window shift and registered output stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            w1          <= '{default: '0};
            w2          <= '{default: '0};
            s.out_valid <= 1'b0;
            s.out_data  <= '0;
            s.out_eof   <= 1'b0;
            frame_done  <= 1'b0;
`ifdef MEDIAN_STATS_EN
            frame_cnt   <= '0;
            abort_cnt   <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            if (take) begin
                w1 <= w2;
                w2 <= '{top, mid, s.in_data};
            end
            if (prod) begin
                s.out_valid <= 1'b1;
                s.out_data  <= med;
                s.out_eof   <= last;
            end else if (s.out_ready) begin
                s.out_valid <= 1'b0;
                s.out_eof   <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (take) begin
                        col   <= CW'(1);
                        row   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (take) begin
                        if (s.in_sof) begin
                            col <= CW'(1);
                            row <= '0;
`ifdef MEDIAN_STATS_EN
                            abort_cnt <= abort_cnt + {7'b0, abort_cnt != 8'hFF};
`endif
                        end else if (col == CW'(IMG_W - 1)) begin
                            col   <= '0;
                            row   <= last ? '0 : row + RW'(1);
                            state <= last ? DONE : RUN;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                default: begin
                    if (s.out_valid && s.out_ready) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
`ifdef MEDIAN_STATS_EN
                        frame_cnt  <= frame_cnt + 16'd1;
`endif
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_median3x3_stream_ctrl.sv
// tb_median3x3_stream_ctrl: directed checks of the 3x3 median stream controller on a 5x5 frame
module tb_median3x3_stream_ctrl;
    localparam int W = 5;
    localparam int H = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_done;
`ifdef MEDIAN_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  abort_cnt;
`endif

    always #5 clk = ~clk;

    median3x3_stream_ctrl_if #(.PIX_W(8)) bus ();

    median3x3_stream_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s(bus),
        .frame_done(frame_done)
`ifdef MEDIAN_STATS_EN
        ,
        .frame_cnt(frame_cnt),
        .abort_cnt(abort_cnt)
`endif
    );

    int n_asrt = 0;
    int n_fail = 0;
    int fd_cnt = 0;
    int stall = 0;
    logic bp_arm = 1'b0;
    logic acc;
    logic eof_hs;
    logic [7:0] oq[$];
    logic eq[$];
    int ramp_exp[9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bus.out_ready = (stall == 0);
        #1;
        if (stall > 0) begin
            chk("stall_out_valid", bus.out_valid, 1);
            chk("stall_out_data", bus.out_data, 6);
            chk("stall_in_ready", bus.in_ready, 0);
            stall--;
        end
        if (bus.out_valid && bus.out_ready) begin
            oq.push_back(bus.out_data);
            eq.push_back(bus.out_eof);
        end
        eof_hs = bus.out_valid && bus.out_ready && bus.out_eof;
        acc = bus.in_valid && bus.in_ready;
        @(posedge clk);
        #1;
        if (frame_done) fd_cnt++;
        if (eof_hs) chk("frame_done_after_eof", frame_done, 1);
        if (bp_arm && bus.out_valid) begin
            bp_arm = 1'b0;
            stall = 4;
        end
    endtask

    function automatic logic [7:0] pix(input int mode, input int r, input int c);
        if (mode == 0) return 8'(r * W + c);
        if (mode == 1) return (r == 2 && c == 2) ? 8'd255 : 8'd50;
        return 8'd100;
    endfunction

    task automatic send_px(input logic [7:0] d, input logic sof);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        bus.in_sof = sof;
        do begin
            tick();
            n++;
        end while (!acc && n < 100);
        if (!acc) chk("accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
    endtask

    task automatic send_range(input int mode, input int npx);
        for (int k = 0; k < npx; k++) send_px(pix(mode, k / W, k % W), k == 0);
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wait_done();
        int n = 0;
        int f0 = fd_cnt;
        while (fd_cnt == f0 && n < 100) begin
            tick();
            n++;
        end
        if (fd_cnt == f0) chk("frame_done_timeout", 0, 1);
    endtask

    task automatic clear();
        oq.delete();
        eq.delete();
        fd_cnt = 0;
    endtask

    task automatic chk_frame(input string tag, input int base, input int cval);
        for (int i = 0; i < 9; i++) begin
            if (base + i < oq.size()) begin
                chk({tag, "_data"}, oq[base+i], cval < 0 ? ramp_exp[i] : cval);
                chk({tag, "_eof"}, eq[base+i], i == 8);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_eof", bus.out_eof, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", bus.in_ready, 1);

        clear();
        send_range(0, 25);
        wait_done();
        drain(2);
        chk("ramp_count", oq.size(), 9);
        chk_frame("ramp", 0, -1);
        chk("ramp_frame_done", fd_cnt, 1);

        clear();
        send_range(1, 25);
        wait_done();
        drain(2);
        chk("impulse_count", oq.size(), 9);
        chk_frame("impulse", 0, 50);

        clear();
        bp_arm = 1'b1;
        send_range(0, 25);
        wait_done();
        drain(2);
        chk("bp_count", oq.size(), 9);
        chk_frame("bp", 0, -1);
        chk("bp_stall_done", stall, 0);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clear();
        send_range(0, 16);
        send_range(2, 25);
        wait_done();
        drain(2);
        chk("abort_count", oq.size(), 12);
        for (int i = 0; i < 3; i++) begin
            if (i < oq.size()) begin
                chk("abort_a_data", oq[i], ramp_exp[i]);
                chk("abort_a_eof", eq[i], 0);
            end
        end
        chk_frame("abort_b", 3, 100);
        chk("abort_frame_done", fd_cnt, 1);
`ifdef MEDIAN_STATS_EN
        chk("stats_frame_cnt", frame_cnt, 1);
        chk("stats_abort_cnt", abort_cnt, 1);
`endif

        clear();
        send_range(0, 13);
        chk("pre_rst_out_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_out_valid", bus.out_valid, 0);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_in_ready", bus.in_ready, 1);
        clear();
        send_px(8'd33, 1'b0);
        send_px(8'd44, 1'b0);
        send_px(8'd55, 1'b0);
        drain(3);
        chk("nosof_no_output", oq.size(), 0);
        chk("nosof_in_ready", bus.in_ready, 1);
        send_range(0, 25);
        wait_done();
        drain(2);
        chk("rst_ramp_count", oq.size(), 9);
        chk_frame("rst_ramp", 0, -1);

        clear();
        send_range(0, 25);
        wait_done();
        send_range(0, 25);
        wait_done();
        drain(2);
        chk("b2b_count", oq.size(), 18);
        chk_frame("b2b_1", 0, -1);
        chk_frame("b2b_2", 9, -1);
        chk("b2b_frame_done", fd_cnt, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
